des_key_schedule: RTL and testbench

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_pkg.sv | 58 +++++
 rtl/des_key_schedule_pc2.sv | 27 ++
 rtl/des_key_schedule.sv | 155 +++++++++++++++
 tb/tb_des_key_schedule.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// ---------------------------------------------------------------------------
// des_pkg -- shared definitions for the DES key schedule.
//
// Contents:
//   des_ks_state_t : schedule FSM states (IDLE, RUN)
//   PC1_TAB        : permuted choice 1, zero-based source index into key_in
//   PC2_TAB        : permuted choice 2, zero-based source index into CD
//   SHIFT_TAB      : per-round left-shift amount, entry r-1 holds shift(r)
//   rotl_cd/rotr_cd: rotate the C and D halves of a CD word independently
//
// Bit convention: index i holds FIPS bit i+1, so the FIPS tables are simply
// decremented by one.
// ---------------------------------------------------------------------------
package des_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } des_ks_state_t;

   // C half occupies entries 0..27, D half entries 28..55.
   localparam logic [5:0] PC1_TAB [56] = '{
      56, 48, 40, 32, 24, 16,  8,  0, 57, 49, 41, 33, 25, 17,
       9,  1, 58, 50, 42, 34, 26, 18, 10,  2, 59, 51, 43, 35,
      62, 54, 46, 38, 30, 22, 14,  6, 61, 53, 45, 37, 29, 21,
      13,  5, 60, 52, 44, 36, 28, 20, 12,  4, 27, 19, 11,  3
   };

   localparam logic [5:0] PC2_TAB [48] = '{
      13, 16, 10, 23,  0,  4,  2, 27, 14,  5, 20,  9,
      22, 18, 11,  3, 25,  7, 15,  6, 26, 19, 12,  1,
      40, 51, 30, 36, 46, 54, 29, 39, 50, 44, 32, 47,
      43, 48, 38, 55, 33, 52, 45, 41, 49, 35, 28, 31
   };

   localparam logic [1:0] SHIFT_TAB [16] = '{
      1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
   };

   // Left rotation moves FIPS bit i+s into position i, which is a shift
   // toward index 0 with wrap-around into the top of the vector.
   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] s);
      return (s == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
      return (s == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
   endfunction

   function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic [1:0] s);
      return {rotl28(cd[55:28], s), rotl28(cd[27:0], s)};
   endfunction

   function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic [1:0] s);
      return {rotr28(cd[55:28], s), rotr28(cd[27:0], s)};
   endfunction

endpackage

// File: rtl/des_key_schedule_pc2.sv
// ---------------------------------------------------------------------------
// des_key_schedule_pc2 -- permuted choice 2, pure combinational.
//
// Ports:
//   cd_in      [55:0] in  : C (bits 27:0) and D (bits 55:28) register
//   subkey_out [47:0] out : round subkey, FIPS bit i+1 at index i
// ---------------------------------------------------------------------------
module des_key_schedule_pc2
   import des_pkg::*;
(
   input  logic [55:0] cd_in,
   output logic [47:0] subkey_out
);

   always_comb begin
      subkey_out = '0;
      for (int i = 0; i < 48; i++) begin
         subkey_out[i] = cd_in[PC2_TAB[i]];
      end
   end

   // PC2 discards eight CD positions by design.
   logic cd_dropped_unused;
   assign cd_dropped_unused = ^{cd_in[53], cd_in[42], cd_in[37], cd_in[34],
                                cd_in[24], cd_in[21], cd_in[17], cd_in[8]};

endmodule

// File: rtl/des_key_schedule.sv
// ---------------------------------------------------------------------------
// des_key_schedule -- streams the 16 DES round subkeys for one key.
//
// Ports:
//   clk, rst (sync, active high)
//   key_valid/key_ready/key_in[63:0]/decrypt : key handshake; decrypt=1
//                                              emits K16..K1
//   subkey_valid/subkey_ready/subkey[47:0]   : subkey handshake
//   round_idx[3:0]                           : output sequence index
//   done                                     : high with the index-15 subkey
//   parity_err                               : key byte parity flag
//
// Bit convention on key_in and subkey: index i holds FIPS bit i+1.
//
// Configuration: define DES_KEY_PARITY_CHECK_EN to register a parity flag on
// each accepted key (set when any byte has even parity). Undefined, the
// flag is tied to 0.
// ---------------------------------------------------------------------------
module des_key_schedule
   import des_pkg::*;
#(
   parameter int ROUNDS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   output logic        key_ready,
   input  logic [63:0] key_in,
   input  logic        decrypt,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [47:0] subkey,
   output logic [3:0]  round_idx,
   output logic        done,
   output logic        parity_err
);

   localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

   des_ks_state_t state_q, state_d;
   logic [55:0]   cd_q, cd_d;
   logic [3:0]    round_idx_q, round_idx_d;
   logic          mode_q, mode_d;
   logic [55:0]   pc1_key;
   logic [47:0]   pc2_subkey;
   logic          key_accept;
   logic          subkey_xfer;

   always_comb begin
      pc1_key = '0;
      for (int i = 0; i < 56; i++) begin
         pc1_key[i] = key_in[PC1_TAB[i]];
      end
   end

   always_comb begin
      // NOTE: every variable gets its default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      cd_d         = cd_q;
      round_idx_d  = round_idx_q;
      mode_d       = mode_q;
      key_ready    = 1'b0;
      subkey_valid = 1'b0;
      key_accept   = 1'b0;
      subkey_xfer  = 1'b0;

      case (state_q)
         IDLE: begin
            key_ready  = 1'b1;
            key_accept = key_valid;
            if (key_accept) begin
               state_d     = RUN;
               mode_d      = decrypt;
               round_idx_d = '0;
               // Encrypt starts at C1D1; decrypt starts at C0D0, which
               // equals C16D16 because the shifts total 28.
               cd_d        = decrypt ? pc1_key : rotl_cd(pc1_key, SHIFT_TAB[0]);
            end
         end
         RUN: begin
            subkey_valid = 1'b1;
            subkey_xfer  = subkey_ready;
            if (subkey_xfer) begin
               if (round_idx_q == LAST_IDX) begin
                  state_d     = IDLE;
                  round_idx_d = '0;
               end else begin
                  round_idx_d = round_idx_q + 4'd1;
                  // Table entry r-1 holds shift(r): encrypt next needs
                  // shift(n+2), decrypt undoes shift(16-n), i.e. entry 15-n.
                  cd_d = mode_q ? rotr_cd(cd_q, SHIFT_TAB[~round_idx_q])
                                : rotl_cd(cd_q, SHIFT_TAB[round_idx_q + 4'd1]);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cd_q        <= '0;
         round_idx_q <= '0;
         mode_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cd_q        <= cd_d;
         round_idx_q <= round_idx_d;
         mode_q      <= mode_d;
      end
   end

   des_key_schedule_pc2 u_pc2 (
      .cd_in      (cd_q),
      .subkey_out (pc2_subkey)
   );

   assign subkey    = subkey_valid ? pc2_subkey : '0;
   assign round_idx = round_idx_q;
   assign done      = subkey_valid && (round_idx_q == LAST_IDX);

`ifdef DES_KEY_PARITY_CHECK_EN
   logic parity_err_q, parity_err_d;
   logic key_even_byte;

   always_comb begin
      key_even_byte = 1'b0;
      for (int j = 0; j < 8; j++) begin
         key_even_byte = key_even_byte | ~(^key_in[8*j +: 8]);
      end
      parity_err_d = key_accept ? key_even_byte : parity_err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   // PC1 drops the eight parity bits; nothing else looks at them here.
   logic key_parity_bits_unused;
   assign key_parity_bits_unused = ^{key_in[63], key_in[55], key_in[47], key_in[39],
                                     key_in[31], key_in[23], key_in[15], key_in[7]};
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_des_key_schedule -- directed bench for des_key_schedule using the
// classic key 133457799BBCDFF1 and its published FIPS-order subkeys.
// ---------------------------------------------------------------------------
module tb_des_key_schedule;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_valid;
   logic        key_ready;
   logic [63:0] key_in;
   logic        decrypt;
   logic        subkey_valid;
   logic        subkey_ready;
   logic [47:0] subkey;
   logic [3:0]  round_idx;
   logic        done;
   logic        parity_err;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [63:0] KEY_F1 = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_F0 = 64'h133457799BBCDFF0;

   // K1..K16 in FIPS order (hex MSB = FIPS bit 1).
   localparam logic [47:0] EXP_K [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
   };

`ifdef DES_KEY_PARITY_CHECK_EN
   // Every byte of ...F1 has odd parity; the final byte F0 has four ones.
   localparam logic PAR_F1 = 1'b0;
   localparam logic PAR_F0 = 1'b1;
`else
   localparam logic PAR_F1 = 1'b0;
   localparam logic PAR_F0 = 1'b0;
`endif

   des_key_schedule #(.ROUNDS(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .key_in       (key_in),
      .decrypt      (decrypt),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .subkey       (subkey),
      .round_idx    (round_idx),
      .done         (done),
      .parity_err   (parity_err)
   );

   always #5 clk = ~clk;

   // FIPS hex puts bit 1 at the MSB; the port puts bit 1 at index 0.
   function automatic logic [63:0] rev64(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = x[63-i];
      return r;
   endfunction

   function automatic logic [47:0] rev48(input logic [47:0] x);
      logic [47:0] r;
      for (int i = 0; i < 48; i++) r[i] = x[47-i];
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and settle just past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_key_ready"},    64'(key_ready),    64'd1);
      check({tag, "_subkey_valid"}, 64'(subkey_valid), 64'd0);
      check({tag, "_subkey_zero"},  64'(subkey),       64'd0);
      check({tag, "_done"},         64'(done),         64'd0);
      check({tag, "_round_idx"},    64'(round_idx),    64'd0);
   endtask

   // Check one full ready=1 pass, index 0 already on the outputs.
   task automatic run_sequence(input string tag, input logic dec);
      logic [3:0] k;
      for (int n = 0; n < 16; n++) begin
         k = dec ? 4'(15 - n) : 4'(n);
         check({tag, "_valid"},  64'(subkey_valid), 64'd1);
         check({tag, "_idx"},    64'(round_idx),    64'(n));
         check({tag, "_subkey"}, 64'(subkey),       64'(rev48(EXP_K[k])));
         check({tag, "_done"},   64'(done),         64'(n == 15));
         step();
      end
   endtask

   logic [3:0] exp_idx;
   logic       rdy;
   logic       finished;

   initial begin
      rst          = 1'b1;
      key_valid    = 1'b0;
      key_in       = '0;
      decrypt      = 1'b0;
      subkey_ready = 1'b0;
      step();
      step();
      check_idle("reset_held");
      check("reset_parity", 64'(parity_err), 64'd0);
      rst = 1'b0;
      step();
      check_idle("reset_released");

      // Encrypt: K1..K16, done on the 16th cycle after accept.
      key_in       = rev64(KEY_F1);
      decrypt      = 1'b0;
      key_valid    = 1'b1;
      subkey_ready = 1'b1;
      step();
      key_valid = 1'b0;
      check("enc_parity", 64'(parity_err), 64'(PAR_F1));
      run_sequence("enc", 1'b0);
      check_idle("enc_end");

      // Decrypt: K16..K1.
      decrypt   = 1'b1;
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      run_sequence("dec", 1'b1);
      check_idle("dec_end");

      // Random back-pressure; outputs must hold while stalled.
      decrypt   = 1'b0;
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      exp_idx   = '0;
      finished  = 1'b0;
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         check("stall_valid",  64'(subkey_valid), 64'd1);
         check("stall_idx",    64'(round_idx),    64'(exp_idx));
         check("stall_subkey", 64'(subkey),       64'(rev48(EXP_K[exp_idx])));
         rdy          = 1'($urandom_range(0, 1));
         subkey_ready = rdy;
         step();
         if (rdy) begin
            if (exp_idx == 4'd15) finished = 1'b1;
            else exp_idx = exp_idx + 4'd1;
         end
      end
      check("stall_completed", 64'(finished), 64'd1);
      subkey_ready = 1'b1;
      check_idle("stall_end");

      // Reset at index 7, asserted together with key_valid.
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      for (int n = 0; n < 7; n++) step();
      check("abort_idx_before", 64'(round_idx), 64'd7);
      check("abort_subkey_before", 64'(subkey), 64'(rev48(EXP_K[7])));
      rst       = 1'b1;
      key_valid = 1'b1;
      step();
      check_idle("abort_after_rst");
      step();
      check("rst_priority_valid", 64'(subkey_valid), 64'd0);
      rst = 1'b0;
      step();
      check("restart_valid",  64'(subkey_valid), 64'd1);
      check("restart_idx",    64'(round_idx),    64'd0);
      check("restart_subkey", 64'(subkey),       64'(rev48(EXP_K[0])));

      // key_valid held through RUN with a different key in decrypt mode.
      key_in  = rev64(KEY_F0);
      decrypt = 1'b1;
      run_sequence("hold", 1'b0);
      check("hold_idle_key_ready", 64'(key_ready),    64'd1);
      check("hold_idle_valid",     64'(subkey_valid), 64'd0);
      step();
      key_valid = 1'b0;
      check("second_parity", 64'(parity_err), 64'(PAR_F0));
      run_sequence("second", 1'b1);
      check_idle("second_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
